// File: rtl/echo_pkg.sv
// Shared types and default sizing for the echo framer capture path.
package echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE
  } state_t;

  localparam int DW_DEFAULT    = 16;
  localparam int DEPTH_DEFAULT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO whose head entry lives in a dedicated output register.
// A push into an empty FIFO bypasses the array and shows at the output next cycle.
module sync_fifo
  import echo_pkg::*;
#(
  parameter int WIDTH = DW_DEFAULT + 1,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] MEM_MAX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    mem_cnt;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  logic push_ok;
  logic pop_ok;
  logic load;
  logic mem_rd;
  logic mem_wr;

  // Capacity is the output register plus DEPTH-1 array entries.
  assign full    = out_valid & (mem_cnt == MEM_MAX);
  assign empty   = ~out_valid;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & out_valid;
  assign load    = ~out_valid | pop_ok;
  assign mem_rd  = load & (mem_cnt != '0);
  assign mem_wr  = push_ok & ~(load & (mem_cnt == '0));
  assign dout    = out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
    end else begin
      if (load) begin
        if (mem_rd) begin
          out_data  <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (push_ok) begin
          out_data  <= din;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
      if (mem_wr && !mem_rd)      mem_cnt <= mem_cnt + 1'b1;
      else if (!mem_wr && mem_rd) mem_cnt <= mem_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/echo_framer.sv
// Captures one frame of ADC samples per frame_sync edge and streams them out
// over AXI-Stream with tlast on the final sample of each frame.
module echo_framer
  import echo_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          frame_sync,
  input  logic [15:0]   frame_len,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          overflow,
  output logic          sync_miss,
  output logic [15:0]   frame_cnt,
  output logic          busy
);

  state_t state;
  state_t state_next;

  logic        sync_q;
  logic        sync_edge;
  logic [15:0] len_q;
  logic [15:0] cnt;
  logic        last;
  logic        push;
  logic        push_ok;
  logic        frame_done;
  logic        start;
  logic        arm;
  logic        fifo_full;
  logic        fifo_empty;
  logic [DW:0] fifo_dout;

  assign sync_edge  = frame_sync & ~sync_q;
  assign last       = (cnt == len_q - 16'd1);
  assign push       = (state == ST_CAPTURE) & adc_valid;
  assign push_ok    = push & ~fifo_full;
  assign frame_done = push_ok & last;
  assign start      = (state == ST_ARMED) & enable & sync_edge & (frame_len != 16'd0);
  assign arm        = (state == ST_IDLE) & enable;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (enable) state_next = ST_ARMED;
      ST_ARMED: begin
        if (!enable)    state_next = ST_IDLE;
        else if (start) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: if (frame_done) state_next = enable ? ST_ARMED : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy   <= (state_next == ST_CAPTURE);
      sync_q <= frame_sync;
    end
  end

  // The counter only moves on accepted pushes, so dropped samples never shorten a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      cnt       <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
      sync_miss <= 1'b0;
    end else begin
      if (start) begin
        len_q <= frame_len;
        cnt   <= '0;
      end else if (push_ok) begin
        cnt <= cnt + 16'd1;
      end
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (arm)                                      overflow <= 1'b0;
      else if (push && fifo_full)                   overflow <= 1'b1;
      if (arm)                                      sync_miss <= 1'b0;
      else if ((state == ST_CAPTURE) && sync_edge)  sync_miss <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({last, adc_data}),
    .pop   (m_axis_tready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_dout[DW-1:0];
  assign m_axis_tlast  = fifo_dout[DW];

endmodule
